// File: rtl/seg7_pkg.sv
// Shared glyph table and code-to-segment helper for the 7-segment display path.
package seg7_pkg;

  localparam int unsigned SEG_W   = 7;
  localparam int unsigned CODE_W  = 4;
  localparam int unsigned MAX_DIG = 8;

  // Active-high glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] GLYPH_0 = 7'h3F;
  localparam logic [SEG_W-1:0] GLYPH_1 = 7'h06;
  localparam logic [SEG_W-1:0] GLYPH_2 = 7'h5B;
  localparam logic [SEG_W-1:0] GLYPH_3 = 7'h4F;
  localparam logic [SEG_W-1:0] GLYPH_4 = 7'h66;
  localparam logic [SEG_W-1:0] GLYPH_5 = 7'h6D;
  localparam logic [SEG_W-1:0] GLYPH_6 = 7'h7D;
  localparam logic [SEG_W-1:0] GLYPH_7 = 7'h07;
  localparam logic [SEG_W-1:0] GLYPH_8 = 7'h7F;
  localparam logic [SEG_W-1:0] GLYPH_9 = 7'h6F;
  localparam logic [SEG_W-1:0] GLYPH_A = 7'h77;
  localparam logic [SEG_W-1:0] GLYPH_B = 7'h7C;
  localparam logic [SEG_W-1:0] GLYPH_C = 7'h39;
  localparam logic [SEG_W-1:0] GLYPH_D = 7'h5E;
  localparam logic [SEG_W-1:0] GLYPH_E = 7'h79;
  localparam logic [SEG_W-1:0] GLYPH_F = 7'h71;
  localparam logic [SEG_W-1:0] BLANK   = 7'h00;

  // Map a 4-bit digit code to its active-high glyph (hex shown as A b C d E F)
  function automatic logic [SEG_W-1:0] bcd_to_seg(input logic [CODE_W-1:0] code);
    logic [SEG_W-1:0] seg;
    seg = BLANK;
    case (code)
      4'h0: seg = GLYPH_0;
      4'h1: seg = GLYPH_1;
      4'h2: seg = GLYPH_2;
      4'h3: seg = GLYPH_3;
      4'h4: seg = GLYPH_4;
      4'h5: seg = GLYPH_5;
      4'h6: seg = GLYPH_6;
      4'h7: seg = GLYPH_7;
      4'h8: seg = GLYPH_8;
      4'h9: seg = GLYPH_9;
      4'hA: seg = GLYPH_A;
      4'hB: seg = GLYPH_B;
      4'hC: seg = GLYPH_C;
      4'hD: seg = GLYPH_D;
      4'hE: seg = GLYPH_E;
      default: seg = GLYPH_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_scan_display_decode.sv
// Combinational digit decoder: code + blank -> active-high {dp,g..a}; dp never lit.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  input  logic       blank,
  output logic [7:0] seg_c
);

  // Blanked digits drive no segments; polarity is applied by the parent
  always_comb begin
    seg_c = 8'h00;
    if (!blank) begin
      seg_c = {1'b0, bcd_to_seg(code)};
    end
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed 7-segment bank driver with frame-synchronous double buffering.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int unsigned NUM_DIG        = 8,
  parameter int unsigned SCAN_DIV       = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4*NUM_DIG-1:0] din,
  input  logic [NUM_DIG-1:0]   dig_en,
  input  logic                 lzb,
  input  logic                 upd_req,
  output logic                 upd_ack,
  output logic [NUM_DIG-1:0]   led_en,
  output logic [7:0]           led_seg
);

  localparam int unsigned IDX_W = $clog2(NUM_DIG);
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);
  localparam int unsigned DIN_W = 4 * NUM_DIG;

  // XOR masks that turn active-high patterns into the board's lit level
  localparam logic [NUM_DIG-1:0] EN_POL  = {NUM_DIG{SEG_ACTIVE_LOW}};
  localparam logic [7:0]         SEG_POL = {8{SEG_ACTIVE_LOW}};

  logic [CNT_W-1:0]   div_cnt_q,  div_cnt_d;
  logic [IDX_W-1:0]   scan_idx_q, scan_idx_d;
  logic [DIN_W-1:0]   stg_din_q,  stg_din_d;
  logic [NUM_DIG-1:0] stg_en_q,   stg_en_d;
  logic               stg_lzb_q,  stg_lzb_d;
  logic [DIN_W-1:0]   shd_din_q,  shd_din_d;
  logic [NUM_DIG-1:0] shd_en_q,   shd_en_d;
  logic               shd_lzb_q,  shd_lzb_d;
  logic               pending_q,  pending_d;
  logic               upd_ack_q,  upd_ack_d;
  logic [NUM_DIG-1:0] led_en_q,   led_en_d;
  logic [7:0]         led_seg_q,  led_seg_d;

  logic               tick;
  logic               frame_end;
  logic [NUM_DIG-1:0] lz_mask;
  logic               seen_nz;
  logic [3:0]         cur_code;
  logic               cur_blank;
  logic [7:0]         dec_seg;

  // Prescaler and digit scan counter; frame ends as the last digit's slot expires
  always_comb begin
    tick       = (div_cnt_q == CNT_W'(SCAN_DIV - 1));
    frame_end  = tick && (scan_idx_q == IDX_W'(NUM_DIG - 1));
    div_cnt_d  = div_cnt_q + CNT_W'(1);
    scan_idx_d = scan_idx_q;
    if (tick) begin
      div_cnt_d  = '0;
      scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIG - 1)) ? '0 : scan_idx_q + IDX_W'(1);
    end
  end

  // Staging/shadow handshake: shadow only moves at frame_end, so a frame never tears
  always_comb begin
    stg_din_d = stg_din_q;
    stg_en_d  = stg_en_q;
    stg_lzb_d = stg_lzb_q;
    shd_din_d = shd_din_q;
    shd_en_d  = shd_en_q;
    shd_lzb_d = shd_lzb_q;
    pending_d = pending_q;
    upd_ack_d = 1'b0;
    // Transfer uses the staging value from before this cycle's request
    if (frame_end && pending_q) begin
      shd_din_d = stg_din_q;
      shd_en_d  = stg_en_q;
      shd_lzb_d = stg_lzb_q;
      pending_d = 1'b0;
      upd_ack_d = 1'b1;
    end
    if (upd_req) begin
      stg_din_d = din;
      stg_en_d  = dig_en;
      stg_lzb_d = lzb;
      pending_d = 1'b1;
    end
  end

  // Leading-zero mask: blank digits above the most significant nonzero one; digit 0 never blanked
  always_comb begin
    lz_mask = '0;
    seen_nz = 1'b0;
    for (int i = NUM_DIG - 1; i >= 1; i--) begin
      seen_nz    = seen_nz | (shd_din_q[4*i +: 4] != 4'h0);
      lz_mask[i] = shd_lzb_q & ~seen_nz;
    end
  end

  // Select the shadow digit currently being scanned
  always_comb begin
    cur_code  = 4'h0;
    cur_blank = 1'b1;
    for (int i = 0; i < NUM_DIG; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        cur_code  = shd_din_q[4*i +: 4];
        cur_blank = ~shd_en_q[i] | lz_mask[i];
      end
    end
  end

  seg7_decode u_decode (
    .code  (cur_code),
    .blank (cur_blank),
    .seg_c (dec_seg)
  );

  // Output stage: one-hot anode plus segments, both at the board's lit level
  always_comb begin
    led_en_d  = (NUM_DIG'(1) << scan_idx_q) ^ EN_POL;
    led_seg_d = dec_seg ^ SEG_POL;
  end

  // State registers with synchronous reset; outputs reset to the unlit level
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q  <= '0;
      scan_idx_q <= '0;
      stg_din_q  <= '0;
      stg_en_q   <= '0;
      stg_lzb_q  <= 1'b0;
      shd_din_q  <= '0;
      shd_en_q   <= '0;
      shd_lzb_q  <= 1'b0;
      pending_q  <= 1'b0;
      upd_ack_q  <= 1'b0;
      led_en_q   <= EN_POL;
      led_seg_q  <= SEG_POL;
    end else begin
      div_cnt_q  <= div_cnt_d;
      scan_idx_q <= scan_idx_d;
      stg_din_q  <= stg_din_d;
      stg_en_q   <= stg_en_d;
      stg_lzb_q  <= stg_lzb_d;
      shd_din_q  <= shd_din_d;
      shd_en_q   <= shd_en_d;
      shd_lzb_q  <= shd_lzb_d;
      pending_q  <= pending_d;
      upd_ack_q  <= upd_ack_d;
      led_en_q   <= led_en_d;
      led_seg_q  <= led_seg_d;
    end
  end

  assign upd_ack = upd_ack_q;
  assign led_en  = led_en_q;
  assign led_seg = led_seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Self-checking bench for seg7_scan_display: cycle-level reference model plus directed scenarios.
module tb_seg7_scan_display;

  localparam int unsigned ND   = 2;
  localparam int unsigned DIV  = 4;
  localparam int unsigned FRM  = ND * DIV;

  logic          clk;
  logic          rst;
  logic [7:0]    din;
  logic [1:0]    dig_en;
  logic          lzb;
  logic          upd_req;
  logic          upd_ack;
  logic [1:0]    led_en;
  logic [7:0]    led_seg;

  int total = 0;
  int bad   = 0;

  // Expected active-low glyphs {dp,g..a} for codes 0..F
  logic [7:0] glyph_al [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  // Reference model state: time since reset, staged/visible display contents
  int         m_cyc;
  logic [7:0] m_stg_din, m_shd_din;
  logic [1:0] m_stg_en,  m_shd_en;
  logic       m_stg_lzb, m_shd_lzb, m_pend;
  logic       m_ack;
  logic [1:0] m_en;
  logic [7:0] m_seg;

  logic [7:0] cur_din;
  logic [1:0] cur_en;
  logic       cur_lzb;

  seg7_scan_display #(
    .NUM_DIG        (ND),
    .SCAN_DIV       (DIV),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .dig_en  (dig_en),
    .lzb     (lzb),
    .upd_req (upd_req),
    .upd_ack (upd_ack),
    .led_en  (led_en),
    .led_seg (led_seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected segment byte for digit position d of a displayed value
  function automatic logic [7:0] exp_seg(input int d, input logic [7:0] v,
                                         input logic [1:0] e, input logic l);
    int code;
    int upper;
    code  = (int'(v) >> (4 * d)) & 15;
    upper = int'(v) >> (4 * d);
    if (!e[d]) return 8'hFF;
    if (l && d > 0 && upper == 0) return 8'hFF;
    return glyph_al[code];
  endfunction

  // Advance the model by one clock edge using the inputs presented before it
  task automatic model_edge(input logic r, input logic req, input logic [7:0] d,
                            input logic [1:0] e, input logic l);
    int  pos;
    bit  fe;
    if (r) begin
      m_cyc = 0; m_pend = 0; m_ack = 0;
      m_stg_din = 0; m_stg_en = 0; m_stg_lzb = 0;
      m_shd_din = 0; m_shd_en = 0; m_shd_lzb = 0;
      m_en = 2'b11; m_seg = 8'hFF;
    end else begin
      pos   = (m_cyc / DIV) % ND;
      fe    = (m_cyc % FRM) == FRM - 1;
      m_en  = ~(2'b01 << pos);
      m_seg = exp_seg(pos, m_shd_din, m_shd_en, m_shd_lzb);
      m_ack = fe && m_pend;
      if (fe && m_pend) begin
        m_shd_din = m_stg_din; m_shd_en = m_stg_en; m_shd_lzb = m_stg_lzb;
        m_pend = 0;
      end
      if (req) begin
        m_stg_din = d; m_stg_en = e; m_stg_lzb = l;
        m_pend = 1;
      end
      m_cyc++;
    end
  endtask

  // One clock: drive, advance model, compare all outputs just after the edge
  task automatic step(input logic r, input logic req, input logic [7:0] d,
                      input logic [1:0] e, input logic l);
    rst = r; upd_req = req; din = d; dig_en = e; lzb = l;
    if (req) begin cur_din = d; cur_en = e; cur_lzb = l; end
    @(posedge clk);
    model_edge(r, req, d, e, l);
    #1;
    chk("led_en", 32'(led_en), 32'(m_en));
    chk("led_seg", 32'(led_seg), 32'(m_seg));
    chk("upd_ack", 32'(upd_ack), 32'(m_ack));
    upd_req = 1'b0;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, cur_din, cur_en, cur_lzb);
  endtask

  task automatic request(input logic [7:0] d, input logic [1:0] e, input logic l);
    step(1'b0, 1'b1, d, e, l);
  endtask

  // Run until the next upd_ack, bounded; returns cycles waited
  task automatic wait_ack(output int lat);
    lat = 99;
    for (int i = 1; i <= 20; i++) begin
      idle();
      if (upd_ack) begin
        lat = i;
        break;
      end
    end
  endtask

  // Idle so the model's next edge is frame-relative cycle ph
  task automatic align(input int ph);
    for (int i = 0; i < 2 * FRM; i++) begin
      if ((m_cyc % FRM) == ph) break;
      idle();
    end
  endtask

  // Watch one full frame and compare each lit digit with fixed glyphs
  task automatic show_check(input string tag, input logic [7:0] d1, input logic [7:0] d0);
    for (int i = 0; i < FRM; i++) begin
      idle();
      if (led_en == 2'b01) chk({tag, "_d1"}, 32'(led_seg), 32'(d1));
      else                 chk({tag, "_d0"}, 32'(led_seg), 32'(d0));
    end
  endtask

  initial begin
    int lat;
    rst = 1'b1; upd_req = 1'b0; din = '0; dig_en = '0; lzb = 1'b0;
    cur_din = '0; cur_en = '0; cur_lzb = 1'b0;

    // Reset and free-running scan with an empty display
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    chk("rst_en", 32'(led_en), 32'(2'b11));
    chk("rst_seg", 32'(led_seg), 32'(8'hFF));
    chk("rst_ack", 32'(upd_ack), 32'(1'b0));
    for (int i = 0; i < 12; i++) idle();

    // Basic update "20"
    request(8'h20, 2'b11, 1'b0);
    wait_ack(lat);
    chk("t2_lat", 32'(lat <= int'(FRM) + 1), 32'(1));
    show_check("t2", 8'hA4, 8'hC0);

    // Leading-zero blanking
    request(8'h07, 2'b11, 1'b1);
    wait_ack(lat);
    chk("t3a_lat", 32'(lat <= int'(FRM) + 1), 32'(1));
    show_check("t3a", 8'hFF, 8'hF8);
    request(8'h00, 2'b11, 1'b1);
    wait_ack(lat);
    show_check("t3b", 8'hFF, 8'hC0);

    // Two requests inside one frame: last wins, single ack
    align(0);
    request(8'h11, 2'b11, 1'b0);
    idle(); idle();
    request(8'h15, 2'b11, 1'b0);
    wait_ack(lat);
    show_check("t4", 8'hF9, 8'h92);

    // Request on the frame_end cycle while another is pending
    align(1);
    request(8'h18, 2'b11, 1'b0);
    align(FRM - 1);
    request(8'h19, 2'b11, 1'b0);
    chk("t5_ack1", 32'(upd_ack), 32'(1'b1));
    show_check("t5a", 8'hF9, 8'h80);
    chk("t5_ack2", 32'(upd_ack), 32'(1'b1));
    show_check("t5b", 8'hF9, 8'h90);

    // Reset with an update pending mid-frame
    align(2);
    request(8'h42, 2'b11, 1'b0);
    idle();
    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 2'b00, 1'b0);
    chk("t6_en", 32'(led_en), 32'(2'b11));
    chk("t6_seg", 32'(led_seg), 32'(8'hFF));
    cur_din = '0; cur_en = '0; cur_lzb = 1'b0;
    show_check("t6", 8'hFF, 8'hFF);
    for (int i = 0; i < FRM; i++) idle();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic       r, q, l;
      logic [7:0] d;
      logic [1:0] e;
      r = ($urandom_range(0, 120) == 0);
      q = ($urandom_range(0, 5) == 0);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom);
      e = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      l = 1'($urandom);
      step(r, q, d, e, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
